scan_line_scheduler: RTL and testbench



---
 rtl/scan_line_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_scan_line_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : scan_line_scheduler
// Purpose  : Buffers laser-beam endpoints in a small FIFO and launches one
//            Bresenham line update per beam, waiting for each line to finish
//            before starting the next. Between lines the shared map RAM can
//            be handed to the scan matcher. Each scan's completion is
//            signalled with a (saturating) beam count.
// Ports    : clock/reset         - system clock, synchronous active-low reset
//            beam_*              - endpoint input stream (valid/ready)
//            line_start/x/y/busy - line drawer handshake
//            match_req/gnt       - map RAM arbitration with the scan matcher
//            scan_done/beams     - per-scan completion pulse and beam count
//            fifo_level          - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module scan_line_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int COORD_W    = 10,
  parameter int CNT_W      = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          beam_valid,
  output logic                          beam_ready,
  input  logic [COORD_W-1:0]            beam_x,
  input  logic [COORD_W-1:0]            beam_y,
  input  logic                          beam_last,
  output logic                          line_start,
  output logic [COORD_W-1:0]            line_x,
  output logic [COORD_W-1:0]            line_y,
  input  logic                          line_busy,
  input  logic                          match_req,
  output logic                          match_gnt,
  output logic                          scan_done,
  output logic [CNT_W-1:0]              scan_beams,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 * COORD_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_ACCEPT = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_MATCH  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [COORD_W-1:0] line_x_q, line_x_d, line_y_q, line_y_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, scan_beams_q, scan_beams_d;
  logic               scan_done_q, scan_done_d;
  logic               gate_q, gate_d;

  logic               push, pop, fifo_empty, fifo_full, line_done;
  logic [EW-1:0]      head;
  logic [CNT_W-1:0]   cnt_inc;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign push       = beam_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];
  assign cnt_inc    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // The gate only blocks re-entry while there is work to launch.
        if (match_req && (!gate_q || fifo_empty)) state_d = S_MATCH;
        else if (!fifo_empty)                     state_d = S_LAUNCH;
      end
      S_LAUNCH: state_d = S_ACCEPT;
      S_ACCEPT: if (line_busy)  state_d = S_DRAW;
      S_DRAW:   if (!line_busy) state_d = S_IDLE;
      S_MATCH:  if (!match_req) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    line_start = (state_q == S_LAUNCH);
    match_gnt  = (state_q == S_MATCH);
    pop        = (state_q == S_LAUNCH);
    line_done  = (state_q == S_DRAW) && !line_busy;
  end

  // ---------------- Datapath next values ----------------
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    line_x_d     = line_x_q;
    line_y_d     = line_y_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    scan_beams_d = scan_beams_q;
    scan_done_d  = 1'b0;
    gate_d       = gate_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    if (pop) begin
      line_x_d = head[EW-2 -: COORD_W];
      line_y_d = head[COORD_W-1:0];
      last_d   = head[EW-1];
      gate_d   = 1'b0;
    end

    if ((state_q == S_MATCH) && !match_req) gate_d = 1'b1;

    if (line_done) begin
      if (last_q) begin
        scan_done_d  = 1'b1;
        scan_beams_d = cnt_inc;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      line_x_q     <= '0;
      line_y_q     <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      scan_beams_q <= '0;
      scan_done_q  <= 1'b0;
      gate_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      line_x_q     <= line_x_d;
      line_y_q     <= line_y_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      scan_beams_q <= scan_beams_d;
      scan_done_q  <= scan_done_d;
      gate_q       <= gate_d;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by the pointers/level.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {beam_last, beam_x, beam_y};
  end

  // During LAUNCH the head entry is forwarded so the drawer sees the new
  // endpoint on the same edge that samples line_start.
  assign line_x     = (state_q == S_LAUNCH) ? head[EW-2 -: COORD_W] : line_x_q;
  assign line_y     = (state_q == S_LAUNCH) ? head[COORD_W-1:0]     : line_y_q;
  assign beam_ready = !fifo_full;
  assign scan_done  = scan_done_q;
  assign scan_beams = scan_beams_q;
  assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_line_scheduler
// Purpose  : Scoreboard bench for scan_line_scheduler with a line drawer model
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_line_scheduler;

  localparam int FIFO_DEPTH = 8;
  localparam int COORD_W    = 10;
  localparam int CNT_W      = 10;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int SAT        = (1 << CNT_W) - 1;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               beam_valid = 1'b0;
  logic               beam_ready;
  logic [COORD_W-1:0] beam_x = '0, beam_y = '0;
  logic               beam_last = 1'b0;
  logic               line_start;
  logic [COORD_W-1:0] line_x, line_y;
  logic               line_busy;
  logic               match_req = 1'b0;
  logic               match_gnt;
  logic               scan_done;
  logic [CNT_W-1:0]   scan_beams;
  logic [LW-1:0]      fifo_level;

  scan_line_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .beam_valid(beam_valid), .beam_ready(beam_ready),
    .beam_x(beam_x), .beam_y(beam_y), .beam_last(beam_last),
    .line_start(line_start), .line_x(line_x), .line_y(line_y),
    .line_busy(line_busy), .match_req(match_req), .match_gnt(match_gnt),
    .scan_done(scan_done), .scan_beams(scan_beams), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- Line drawer model ----------------
  int   busy_len = 4;
  logic hold     = 1'b0;
  int   rem      = 0;
  logic busy_r   = 1'b0;
  assign line_busy = busy_r;

  always @(posedge clock) begin
    if (!reset) begin
      busy_r <= 1'b0;
      rem    <= 0;
    end else if (line_start) begin
      busy_r <= 1'b1;
      rem    <= busy_len;
    end else if (busy_r && !hold) begin
      if (rem <= 1) busy_r <= 1'b0;
      else          rem    <= rem - 1;
    end
  end

  // ---------------- Reference model / scoreboard ----------------
  logic [2*COORD_W-1:0] exp_lines[$];
  int                   exp_done[$];
  int                   model_cnt = 0;

  function automatic void model_accept(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                       input logic last);
    exp_lines.push_back({x, y});
    if (model_cnt < SAT) model_cnt++;
    if (last) begin
      exp_done.push_back(model_cnt);
      model_cnt = 0;
    end
  endfunction

  function automatic void model_reset();
    exp_lines.delete();
    exp_done.delete();
    model_cnt = 0;
  endfunction

  // ---------------- Monitor ----------------
  logic                 inflight = 1'b0;
  logic                 seen_busy = 1'b0;
  logic [2*COORD_W-1:0] cap_xy = '0;

  always @(negedge clock) begin
    if (!reset) begin
      inflight  = 1'b0;
      seen_busy = 1'b0;
    end else begin
      if (line_start) begin
        if (exp_lines.size() == 0) check("unexpected_line_start", 1, 0);
        else check("line_xy", {line_x, line_y}, exp_lines.pop_front());
        cap_xy    = {line_x, line_y};
        inflight  = 1'b1;
        seen_busy = 1'b0;
      end else if (inflight) begin
        if (line_busy) begin
          seen_busy = 1'b1;
          check("line_xy_stable", {line_x, line_y}, cap_xy);
        end else if (seen_busy) begin
          inflight = 1'b0;
        end
      end
      if (match_gnt) check("gnt_during_line", inflight || line_start, 0);
      if (scan_done) begin
        if (exp_done.size() == 0) check("unexpected_scan_done", 1, 0);
        else check("scan_beams", scan_beams, exp_done.pop_front());
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y, input logic last);
    int n = 0;
    beam_valid = 1'b1; beam_x = x; beam_y = y; beam_last = last;
    @(negedge clock);
    while (!beam_ready && n < 400) begin
      n++;
      @(negedge clock);
    end
    if (!beam_ready) check("push_timeout", 1, 0);
    else model_accept(x, y, last);
    @(posedge clock); #1;
    beam_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_lines.size() != 0 || exp_done.size() != 0 || line_busy) && n < bound) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_timeout", n >= bound, 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic wait_busy(input int bound);
    int n = 0;
    @(negedge clock);
    while (!line_busy && n < bound) begin n++; @(negedge clock); end
    check("busy_wait_timeout", line_busy, 1);
  endtask

  logic stim_done = 1'b0;

  initial begin
    // ---- Reset state ----
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_beam_ready", beam_ready, 1);
    check("rst_line_start", line_start, 0);
    check("rst_line_x", line_x, 0);
    check("rst_line_y", line_y, 0);
    check("rst_match_gnt", match_gnt, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_scan_beams", scan_beams, 0);
    check("rst_fifo_level", fifo_level, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // ---- Single beam with launch latency ----
    busy_len = 4;
    push(10'd5, 10'd3, 1'b1);
    @(negedge clock);
    check("latency_cycle_n", line_start, 0);
    @(negedge clock);
    check("latency_cycle_n1", line_start, 1);
    @(posedge clock); #1;
    wait_drain(100);

    // ---- Three beams back-to-back, 2-cycle gap between lines ----
    begin
      int cyc = 0, fall = -1, starts = 0, dones = 0;
      logic pb = 1'b0;
      busy_len = 3;
      push(10'd100, 10'd200, 1'b0);
      push(10'd101, 10'd201, 1'b0);
      push(10'd102, 10'd202, 1'b1);
      while (cyc < 200 && dones == 0) begin
        @(negedge clock);
        if (pb && !line_busy) fall = cyc;
        if (line_start) begin
          starts++;
          if (fall >= 0) check("b2b_gap", cyc - fall, 2);
        end
        if (scan_done) dones++;
        pb = line_busy;
        cyc++;
      end
      check("b2b_dones", dones, 1);
      @(posedge clock); #1;
      wait_drain(100);
    end

    // ---- Fill FIFO with drawer held busy ----
    hold = 1'b1;
    busy_len = 2;
    push(10'd1, 10'd1, 1'b0);
    for (int i = 0; i < FIFO_DEPTH; i++) push(10'(20 + i), 10'(40 + i), 1'b0);
    @(negedge clock);
    check("full_level", fifo_level, FIFO_DEPTH);
    check("full_ready", beam_ready, 0);
    @(posedge clock); #1;
    fork
      push(10'd77, 10'd88, 1'b1);
      begin
        repeat (4) @(negedge clock);
        check("overflow_held", beam_ready, 0);
        @(posedge clock); #1;
        hold = 1'b0;
      end
    join
    wait_drain(400);

    // ---- Matcher arbitration and fairness gate ----
    begin
      int n = 0, starts = 0;
      logic done_seen = 1'b0;
      busy_len = 6;
      push(10'd9, 10'd9, 1'b1);
      wait_busy(50);
      @(posedge clock); #1;
      match_req = 1'b1;
      @(negedge clock);
      while (!match_gnt && n < 100) begin
        if (scan_done) done_seen = 1'b1;
        n++;
        @(negedge clock);
      end
      check("gnt_rise", match_gnt, 1);
      check("gnt_after_line", done_seen, 1);
      @(posedge clock); #1;
      push(10'd11, 10'd12, 1'b0);
      push(10'd13, 10'd14, 1'b1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("match_holds_fifo", fifo_level, 2);
      check("match_still_gnt", match_gnt, 1);
      @(posedge clock); #1;
      match_req = 1'b0;
      @(posedge clock); #1;
      match_req = 1'b1;
      n = 0;
      @(negedge clock);
      check("gnt_fall", match_gnt, 0);
      while (!match_gnt && n < 100) begin
        if (line_start) starts++;
        n++;
        @(negedge clock);
      end
      check("gate_regrant", match_gnt, 1);
      check("gate_one_line", starts, 1);
      @(posedge clock); #1;
      match_req = 1'b0;
      wait_drain(200);
    end

    // ---- Reset in the middle of DRAW ----
    begin
      int starts = 0;
      hold = 1'b1;
      push(10'd31, 10'd32, 1'b0);
      push(10'd33, 10'd34, 1'b0);
      push(10'd35, 10'd36, 1'b0);
      wait_busy(50);
      repeat (2) @(negedge clock);
      check("pre_reset_level", fifo_level, 2);
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      hold = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      check("mid_rst_beam_ready", beam_ready, 1);
      check("mid_rst_line_start", line_start, 0);
      check("mid_rst_line_x", line_x, 0);
      check("mid_rst_line_y", line_y, 0);
      check("mid_rst_match_gnt", match_gnt, 0);
      check("mid_rst_scan_done", scan_done, 0);
      check("mid_rst_scan_beams", scan_beams, 0);
      check("mid_rst_fifo_level", fifo_level, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (20) begin
        @(negedge clock);
        if (line_start) starts++;
      end
      check("no_start_after_rst", starts, 0);
      @(posedge clock); #1;
    end

    // ---- Counter saturation ----
    busy_len = 1;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) push(10'(i), 10'(i >> 3), 1'b0);
    push(10'd1, 10'd2, 1'b1);
    wait_drain(2000);

    // ---- Randomised traffic with a contending matcher ----
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          busy_len = $urandom_range(1, 5);
          push(10'($urandom), 10'($urandom), (i == 59) || ($urandom_range(0, 3) == 0));
          repeat ($urandom_range(0, 3)) @(posedge clock);
          #1;
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          repeat ($urandom_range(1, 15)) @(posedge clock);
          #1;
          match_req = 1'b1;
          repeat ($urandom_range(1, 6)) @(posedge clock);
          #1;
          match_req = 1'b0;
        end
      end
    join
    wait_drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
